// File: rtl/mmio_pkg.sv
// Shared encodings, read-pipeline stage type and helpers for the MMIO region router.
package mmio_pkg;

  localparam int MAX_REGIONS = 16;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_UNMAPPED   = 2'b01;
  localparam logic [1:0] ERR_MISALIGNED = 2'b10;
  localparam logic [1:0] ERR_RO_WRITE   = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
    logic [1:0] off;
    logic [2:0] memop;
    logic       err;
  } rd_stage_t;

  // Region i sits at i<<20; callers slice off as many entries as they use.
  function automatic logic [MAX_REGIONS*32-1:0] default_bases();
    logic [MAX_REGIONS*32-1:0] bases;
    bases = '0;
    for (int i = 0; i < MAX_REGIONS; i++) begin
      bases[i*32 +: 32] = 32'(i) << 20;
    end
    return bases;
  endfunction

  localparam logic [MAX_REGIONS*32-1:0] DEFAULT_BASES = default_bases();

  // Undefined memop codes are treated as misaligned so they never reach a slave.
  function automatic logic is_misaligned(input logic [2:0] memop, input logic [1:0] off);
    logic bad;
    case (memop)
      MEMOP_B, MEMOP_BU: bad = 1'b0;
      MEMOP_H, MEMOP_HU: bad = off[0];
      MEMOP_W:           bad = (off != 2'b00);
      default:           bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mmio_lane_align.sv
// Byte-lane logic: strobe/replicate on the store side, extract/extend on the load side.
module mmio_lane_align
  import mmio_pkg::*;
(
  input  logic [2:0]  wr_memop,
  input  logic [1:0]  wr_off,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_lanes,
  input  logic [2:0]  rd_memop,
  input  logic [1:0]  rd_off,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_data
);

  logic [7:0]  rd_byte_s;
  logic [15:0] rd_half_s;

  // Store side: strobes follow the byte offset, data is replicated into every lane.
  always_comb begin
    wr_be    = 4'b0000;
    wr_lanes = wr_data;
    case (wr_memop)
      MEMOP_B, MEMOP_BU: begin
        wr_be    = 4'b0001 << wr_off;
        wr_lanes = {4{wr_data[7:0]}};
      end
      MEMOP_H, MEMOP_HU: begin
        wr_be    = 4'b0011 << wr_off;
        wr_lanes = {2{wr_data[15:0]}};
      end
      MEMOP_W: begin
        wr_be    = 4'b1111;
        wr_lanes = wr_data;
      end
      default: begin
        wr_be    = 4'b0000;
        wr_lanes = wr_data;
      end
    endcase
  end

  // Load side: pick the addressed byte/half, then sign- or zero-extend.
  always_comb begin
    rd_byte_s = 8'h00;
    case (rd_off)
      2'd0:    rd_byte_s = rd_word[7:0];
      2'd1:    rd_byte_s = rd_word[15:8];
      2'd2:    rd_byte_s = rd_word[23:16];
      default: rd_byte_s = rd_word[31:24];
    endcase
    rd_half_s = rd_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (rd_memop)
      MEMOP_B:  rd_data = {{24{rd_byte_s[7]}}, rd_byte_s};
      MEMOP_BU: rd_data = {24'h000000, rd_byte_s};
      MEMOP_H:  rd_data = {{16{rd_half_s[15]}}, rd_half_s};
      MEMOP_HU: rd_data = {16'h0000, rd_half_s};
      MEMOP_W:  rd_data = rd_word;
      default:  rd_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mmio_region_router.sv
// Per-region MMIO decoder with latency-matched read return.
// Optional sticky error capture is enabled by defining MMIO_ERR_CAPTURE_EN.
module mmio_region_router
  import mmio_pkg::*;
#(
  parameter int                        NUM_REGIONS = 8,
  parameter logic [31:0]               PREFIX_MASK = 32'hfff0_0000,
  parameter logic [NUM_REGIONS*32-1:0] REGION_BASE = DEFAULT_BASES[NUM_REGIONS*32-1:0],
  parameter logic [NUM_REGIONS-1:0]    RO_MASK     = NUM_REGIONS'(1),
  parameter int                        RD_LATENCY  = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wrdata,
  input  logic [2:0]                  cpu_memop,
  input  logic                        cpu_we,
  input  logic                        cpu_re,
  output logic [31:0]                 cpu_rddata,
  output logic                        cpu_rdvalid,
  output logic [31:0]                 slv_addr,
  output logic [31:0]                 slv_wrdata,
  output logic [3:0]                  slv_be,
  output logic [NUM_REGIONS-1:0]      slv_we,
  output logic [NUM_REGIONS-1:0]      slv_re,
  input  logic [NUM_REGIONS*32-1:0]   slv_rddata,
  output logic                        err_valid,
  output logic                        err_overflow,
  output logic [31:0]                 err_addr,
  output logic [1:0]                  err_code,
  output logic                        err_is_write,
  input  logic                        err_clr
);

  logic                   hit_s, ro_s, acc_s, load_s, err_s;
  logic [3:0]             hit_idx_s;
  logic [1:0]             code_s;
  logic [NUM_REGIONS-1:0] onehot_s;
  logic [31:0]            rd_word_s, rd_ext_s;
  rd_stage_t              pipe_r [RD_LATENCY];
  rd_stage_t              last_s;
  logic [31:0]            rddata_r;
  logic                   rdvalid_r;

  // Region match: scan downward so the lowest matching index is the one kept.
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = 4'd0;
    ro_s      = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((cpu_addr & PREFIX_MASK) == REGION_BASE[i*32 +: 32]) begin
        hit_s     = 1'b1;
        hit_idx_s = 4'(i);
        ro_s      = RO_MASK[i];
      end else begin
        hit_s     = hit_s;
      end
    end
  end

  always_comb begin
    onehot_s = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      onehot_s[i] = hit_s && (hit_idx_s == 4'(i));
    end
  end

  // A simultaneous store and load is handled as the store alone.
  assign acc_s  = cpu_we | cpu_re;
  assign load_s = cpu_re & ~cpu_we;

  // Error classification: unmapped beats misaligned beats read-only write.
  always_comb begin
    code_s = ERR_NONE;
    if (!acc_s) begin
      code_s = ERR_NONE;
    end else if (!hit_s) begin
      code_s = ERR_UNMAPPED;
    end else if (is_misaligned(cpu_memop, cpu_addr[1:0])) begin
      code_s = ERR_MISALIGNED;
    end else if (cpu_we && ro_s) begin
      code_s = ERR_RO_WRITE;
    end else begin
      code_s = ERR_NONE;
    end
  end

  assign err_s    = (code_s != ERR_NONE);
  assign slv_we   = (cpu_we && !err_s) ? onehot_s : '0;
  assign slv_re   = (load_s && !err_s) ? onehot_s : '0;
  assign slv_addr = cpu_addr & ~PREFIX_MASK & 32'hffff_fffc;

  mmio_lane_align u_lane (
    .wr_memop (cpu_memop),
    .wr_off   (cpu_addr[1:0]),
    .wr_data  (cpu_wrdata),
    .wr_be    (slv_be),
    .wr_lanes (slv_wrdata),
    .rd_memop (last_s.memop),
    .rd_off   (last_s.off),
    .rd_word  (rd_word_s),
    .rd_data  (rd_ext_s)
  );

  // Read pipeline sized so the last stage lines up with the slave's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LATENCY; i++) pipe_r[i] <= '0;
    end else begin
      pipe_r[0] <= '{valid: load_s, idx: hit_idx_s, off: cpu_addr[1:0],
                     memop: cpu_memop, err: err_s};
      for (int i = 1; i < RD_LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
    end
  end

  assign last_s = pipe_r[RD_LATENCY-1];

  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (last_s.idx == 4'(i)) begin
        rd_word_s = slv_rddata[i*32 +: 32];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Load return register; errored loads come back as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdvalid_r <= 1'b0;
      rddata_r  <= 32'h0000_0000;
    end else begin
      rdvalid_r <= last_s.valid;
      if (last_s.valid) rddata_r <= last_s.err ? 32'h0000_0000 : rd_ext_s;
    end
  end

  assign cpu_rdvalid = rdvalid_r;
  assign cpu_rddata  = rddata_r;

`ifdef MMIO_ERR_CAPTURE_EN
  logic        err_valid_r, err_overflow_r, err_is_write_r;
  logic [31:0] err_addr_r;
  logic [1:0]  err_code_r;

  // A clear arriving with a new error frees the slot, so the new error is captured cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid_r    <= 1'b0;
      err_overflow_r <= 1'b0;
      err_is_write_r <= 1'b0;
      err_addr_r     <= 32'h0000_0000;
      err_code_r     <= ERR_NONE;
    end else if (err_s) begin
      if (!err_valid_r || err_clr) begin
        err_valid_r    <= 1'b1;
        err_overflow_r <= 1'b0;
        err_is_write_r <= cpu_we;
        err_addr_r     <= cpu_addr;
        err_code_r     <= code_s;
      end else begin
        err_overflow_r <= 1'b1;
      end
    end else if (err_clr) begin
      err_valid_r    <= 1'b0;
      err_overflow_r <= 1'b0;
    end
  end

  assign err_valid    = err_valid_r;
  assign err_overflow = err_overflow_r;
  assign err_addr     = err_addr_r;
  assign err_code     = err_code_r;
  assign err_is_write = err_is_write_r;
`else
  logic unused_err_clr_s;
  assign unused_err_clr_s = err_clr;
  assign err_valid        = 1'b0;
  assign err_overflow     = 1'b0;
  assign err_addr         = 32'h0000_0000;
  assign err_code         = ERR_NONE;
  assign err_is_write     = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_region_router.sv
// Scoreboard bench: a latency-1 instance for decode/lane/error steps, a latency-3 instance for pipelining and reset.
`timescale 1ns/1ps
module tb_mmio_region_router;
  import mmio_pkg::*;

`ifdef MMIO_ERR_CAPTURE_EN
  localparam logic CAP_EN = 1'b1;
`else
  localparam logic CAP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n1, we1, re1, clr1, rdv1, ev1, eo1, ew1;
  logic [31:0] addr1, wd1, rd1, saddr1, swd1, ea1;
  logic [2:0]  memop1;
  logic [3:0]  sbe1;
  logic [7:0]  swe1, sre1;
  logic [1:0]  ec1;
  logic [255:0] srd1;

  logic        rst_n2, we2, re2, clr2, rdv2, ev2, eo2, ew2;
  logic [31:0] addr2, wd2, rd2, saddr2, swd2, ea2;
  logic [2:0]  memop2;
  logic [3:0]  sbe2;
  logic [7:0]  swe2, sre2;
  logic [1:0]  ec2;
  logic [255:0] srd2;

  mmio_region_router u_dut1 (
    .clk(clk), .rst_n(rst_n1), .cpu_addr(addr1), .cpu_wrdata(wd1), .cpu_memop(memop1),
    .cpu_we(we1), .cpu_re(re1), .cpu_rddata(rd1), .cpu_rdvalid(rdv1),
    .slv_addr(saddr1), .slv_wrdata(swd1), .slv_be(sbe1), .slv_we(swe1), .slv_re(sre1),
    .slv_rddata(srd1), .err_valid(ev1), .err_overflow(eo1), .err_addr(ea1),
    .err_code(ec1), .err_is_write(ew1), .err_clr(clr1));

  mmio_region_router #(.RD_LATENCY(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n2), .cpu_addr(addr2), .cpu_wrdata(wd2), .cpu_memop(memop2),
    .cpu_we(we2), .cpu_re(re2), .cpu_rddata(rd2), .cpu_rdvalid(rdv2),
    .slv_addr(saddr2), .slv_wrdata(swd2), .slv_be(sbe2), .slv_we(swe2), .slv_re(sre2),
    .slv_rddata(srd2), .err_valid(ev2), .err_overflow(eo2), .err_addr(ea2),
    .err_code(ec2), .err_is_write(ew2), .err_clr(clr2));

  function automatic logic [31:0] slave_word(input int r);
    case (r)
      1:       return 32'h80FF_7F01;
      5:       return 32'h1234_5678;
      default: return 32'h0BAD_0000 | 32'(r);
    endcase
  endfunction

  // Slave models: data is only presented exactly RD_LATENCY cycles after the read strobe.
  logic [7:0] re1_d = 8'h00, re2_d0 = 8'h00, re2_d1 = 8'h00, re2_d2 = 8'h00;
  always @(posedge clk) begin
    re1_d  <= sre1;
    re2_d0 <= sre2;
    re2_d1 <= re2_d0;
    re2_d2 <= re2_d1;
  end
  for (genvar g = 0; g < 8; g++) begin : g_slv
    assign srd1[g*32 +: 32] = re1_d[g]  ? slave_word(g) : 32'hDEAD_0000;
    assign srd2[g*32 +: 32] = re2_d2[g] ? slave_word(g) : 32'hDEAD_0000;
  end

  typedef struct { logic [31:0] data; int at; } exp_t;
  exp_t q1[$], q2[$];
  exp_t e1, e2;
  int n_cmp = 0, n_err = 0, rdv2_cnt = 0, base_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_err(input string tag, input logic v, input logic o,
                           input logic [1:0] c, input logic [31:0] a, input logic w);
    check({tag, "_flags"}, {30'd0, ev1, eo1}, {30'd0, v & CAP_EN, o & CAP_EN});
    if (v) begin
      check({tag, "_code"}, {29'd0, ec1, ew1}, CAP_EN ? {29'd0, c, w} : 32'd0);
      check({tag, "_addr"}, ea1, CAP_EN ? a : 32'd0);
    end
  endtask

  task automatic drive1(input logic we, input logic re, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] d);
    we1 = we; re1 = re; memop1 = m; addr1 = a; wd1 = d;
  endtask

  task automatic drive2(input logic re, input logic [31:0] a);
    we2 = 1'b0; re2 = re; memop2 = MEMOP_W; addr2 = a; wd2 = 32'd0;
  endtask

  task automatic push1(input logic [31:0] d);
    exp_t e;
    e.data = d; e.at = cyc + 2;
    q1.push_back(e);
  endtask

  task automatic push2(input logic [31:0] d);
    exp_t e;
    e.data = d; e.at = cyc + 4;
    q2.push_back(e);
  endtask

  // Return monitors: pop the scoreboard on every rdvalid and check data and arrival cycle.
  always @(negedge clk) begin
    if (rdv1) begin
      check("dut1_q_nonempty", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e1 = q1.pop_front();
        check("dut1_rddata", rd1, e1.data);
        check("dut1_rdvalid_cycle", 32'(cyc), 32'(e1.at));
      end
    end
    if (rdv2) begin
      rdv2_cnt++;
      check("dut2_q_nonempty", 32'(q2.size() != 0), 32'd1);
      if (q2.size() != 0) begin
        e2 = q2.pop_front();
        check("dut2_rddata", rd2, e2.data);
        check("dut2_rdvalid_cycle", 32'(cyc), 32'(e2.at));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n1 = 1'b0; rst_n2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    drive1(1'b0, 1'b0, MEMOP_W, 32'd0, 32'd0);
    drive2(1'b0, 32'd0);
    #1;
    check("reset_rdvalid", {31'd0, rdv1}, 32'd0);
    check("reset_rddata", rd1, 32'd0);
    check("reset_strobes", {24'd0, swe1 | sre1}, 32'd0);
    check_err("reset_err", 1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst_n1 = 1'b1; rst_n2 = 1'b1;

    @(negedge clk); drive1(1'b1, 1'b0, MEMOP_W, 32'h0010_0004, 32'hDEAD_BEEF); #1;
    check("sw_we", {24'd0, swe1}, 32'h02);
    check("sw_be", {28'd0, sbe1}, 32'hF);
    check("sw_addr", saddr1, 32'h4);
    check("sw_data", swd1, 32'hDEAD_BEEF);
    check("sw_re", {24'd0, sre1}, 32'h0);

    @(negedge clk); check_err("sw_ok", 1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
    drive1(1'b1, 1'b0, MEMOP_B, 32'h0010_0003, 32'h0000_00A5); #1;
    check("sb_be", {28'd0, sbe1}, 32'h8);
    check("sb_data", swd1, 32'hA5A5_A5A5);
    check("sb_we", {24'd0, swe1}, 32'h02);

    @(negedge clk); drive1(1'b0, 1'b1, MEMOP_B, 32'h0010_0003, 32'd0); #1;
    check("lb_re", {24'd0, sre1}, 32'h02);
    check("lb_we", {24'd0, swe1}, 32'h00);
    push1(32'hFFFF_FF80);
    @(negedge clk); drive1(1'b0, 1'b1, MEMOP_HU, 32'h0010_0002, 32'd0); push1(32'h0000_80FF);
    @(negedge clk); drive1(1'b0, 1'b1, MEMOP_H, 32'h0010_0002, 32'd0); push1(32'hFFFF_80FF);
    @(negedge clk); drive1(1'b0, 1'b1, MEMOP_W, 32'h0050_0000, 32'd0); #1;
    check("lw5_re", {24'd0, sre1}, 32'h20);
    push1(32'h1234_5678);
    @(negedge clk); drive1(1'b0, 1'b1, MEMOP_BU, 32'h0010_0001, 32'd0); push1(32'h0000_007F);

    @(negedge clk); drive1(1'b0, 1'b1, MEMOP_W, 32'h0090_0000, 32'd0); #1;
    check("unmapped_re", {24'd0, sre1}, 32'h0);
    push1(32'd0);
    @(negedge clk); check_err("unmapped", 1'b1, 1'b0, ERR_UNMAPPED, 32'h0090_0000, 1'b0);
    drive1(1'b1, 1'b0, MEMOP_W, 32'h0000_0010, 32'h1); #1;
    check("ro_we_blocked", {24'd0, swe1}, 32'h0);
    @(negedge clk); check_err("overflow", 1'b1, 1'b1, ERR_UNMAPPED, 32'h0090_0000, 1'b0);
    drive1(1'b0, 1'b0, MEMOP_W, 32'd0, 32'd0); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0; check_err("cleared", 1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
    drive1(1'b1, 1'b0, MEMOP_W, 32'h0000_0020, 32'h2); #1;
    check("ro_we_blocked2", {24'd0, swe1}, 32'h0);
    @(negedge clk); check_err("ro_write", 1'b1, 1'b0, ERR_RO_WRITE, 32'h0000_0020, 1'b1);
    drive1(1'b0, 1'b1, MEMOP_H, 32'h0010_0001, 32'd0); clr1 = 1'b1; #1;
    check("mis_re", {24'd0, sre1}, 32'h0);
    push1(32'd0);
    @(negedge clk); clr1 = 1'b0;
    check_err("mis_with_clr", 1'b1, 1'b0, ERR_MISALIGNED, 32'h0010_0001, 1'b0);
    drive1(1'b0, 1'b0, MEMOP_W, 32'd0, 32'd0); clr1 = 1'b1;
    @(negedge clk); clr1 = 1'b0; check_err("cleared2", 1'b0, 1'b0, 2'b00, 32'd0, 1'b0);
    drive1(1'b0, 1'b1, 3'b011, 32'h0010_0000, 32'd0); #1;
    check("badop_re", {24'd0, sre1}, 32'h0);
    push1(32'd0);
    @(negedge clk); check_err("bad_memop", 1'b1, 1'b0, ERR_MISALIGNED, 32'h0010_0000, 1'b0);
    drive1(1'b1, 1'b1, MEMOP_W, 32'h0020_0000, 32'h1122_3344); #1;
    check("we_re_we", {24'd0, swe1}, 32'h04);
    check("we_re_re", {24'd0, sre1}, 32'h00);
    @(negedge clk); drive1(1'b0, 1'b0, MEMOP_W, 32'd0, 32'd0);
    check_err("we_re_no_err", 1'b1, 1'b0, ERR_MISALIGNED, 32'h0010_0000, 1'b0);
    for (int i = 0; i < 20 && q1.size() != 0; i++) @(negedge clk);
    check("dut1_drain", 32'(q1.size()), 32'd0);

    @(negedge clk); drive2(1'b1, 32'h0010_0000); push2(32'h80FF_7F01);
    @(negedge clk); drive2(1'b1, 32'h0050_0000); push2(32'h1234_5678);
    @(negedge clk); drive2(1'b1, 32'h0010_0000); push2(32'h80FF_7F01);
    @(negedge clk); drive2(1'b0, 32'd0);
    for (int i = 0; i < 20 && q2.size() != 0; i++) @(negedge clk);
    check("dut2_drain", 32'(q2.size()), 32'd0);

    @(negedge clk); drive2(1'b1, 32'h0010_0000);
    @(negedge clk); drive2(1'b0, 32'd0);
    @(negedge clk); rst_n2 = 1'b0; base_cnt = rdv2_cnt; #1;
    check("dut2_rst_rdvalid", {31'd0, rdv2}, 32'd0);
    @(negedge clk); rst_n2 = 1'b1;
    repeat (8) @(negedge clk);
    check("no_rdv_after_rst", 32'(rdv2_cnt), 32'(base_cnt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mmio_region_router.md
# mmio_region_router

Parametrised MMIO decoder between the CPU data port and up to NUM_REGIONS memory-mapped slaves: data RAM, VGA info, char/colour RAMs, keyboard info, temp stack, and later peripherals. It replaces fixed prefix decoding with a per-region base table. It adds byte-lane write strobes, read-only regions, a pipelined read-return path matched to slave latency, byte/half extraction with sign extension, and sticky capture of unmapped, misaligned and illegal accesses.

## Interface
- NUM_REGIONS, 8: slave channel count, 1..16.
- PREFIX_MASK, 32'hfff00000: address bits compared against region bases.
- REGION_BASE, region i = i<<20: packed NUM_REGIONS×32 base vector.
- RO_MASK, 8'b0000_0001: bit i set means region i is read-only.
- RD_LATENCY, 1: slave read latency in cycles, 1..4. All slaves share it.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous active-low.
- cpu_addr  in  32  byte address.
- cpu_wrdata  in  32  store data, LSB-aligned.
- cpu_memop  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu.
- cpu_we / cpu_re  in  1  store / load request, single cycle.
- cpu_rddata  out  32  aligned, extended load result.
- cpu_rdvalid  out  1  load result valid pulse.
- slv_addr  out  32  cpu_addr & ~PREFIX_MASK, word-aligned (bits[1:0]=0).
- slv_wrdata  out  32  store data replicated into lanes.
- slv_be  out  4  byte-lane strobes.
- slv_we / slv_re  out  NUM_REGIONS  one-hot per-region strobes.
- slv_rddata  in  NUM_REGIONS×32  raw word from each slave.
- err_valid  out  1  sticky error flag.
- err_overflow  out  1  error seen while err_valid set.
- err_addr  out  32  captured address.
- err_code  out  2  01 unmapped, 10 misaligned, 11 write to RO.
- err_is_write  out  1  captured access was a store.
- err_clr  in  1  clear error state.

## Operation
- Decode: region i hits when (cpu_addr & PREFIX_MASK) == REGION_BASE[i]. Lowest index wins.
- Alignment: h/hu requires addr[0]=0; w requires addr[1:0]=0; memop 011/110/111 counts as misaligned.
- Byte enables: b → 4'b0001<<addr[1:0]; h → 4'b0011<<addr[1:0]; w → 4'b1111.
- Write data: b replicates byte×4, h replicates half×2.
- Strobes are combinational and only fire for a legal hit. Any error suppresses slv_we/slv_re.
- Read pipeline: RD_LATENCY stages carry {valid, region idx, addr[1:0], memop, err}.
- At the last stage, select slv_rddata[idx] and extract the byte/half. b/h sign-extend; bu/hu zero-extend.
- Register the result into cpu_rddata. Errored loads still return, with data 0.
- cpu_we and cpu_re both high is a protocol error: behave as a store, and issue no load.
- Error capture is gated by MMIO_ERR_CAPTURE_EN:
  - First error loads err_addr, err_code and err_is_write, and sets err_valid.
  - A later error with err_valid set sets only err_overflow.
  - err_clr clears err_valid and err_overflow. If err_clr coincides with a new error, the new error is captured and err_overflow stays 0.

## Timing
- Reset values: all outputs 0; pipeline valids 0.
- Store: slave write strobes are combinational, so the write commits at the same clk edge as the request.
- Load: request at cycle T gives cpu_rdvalid at T+RD_LATENCY+1, one cycle wide. Throughput is one load per cycle.
- Error flags update at the clock edge after the offending request.
- rst_n asserted mid-load drops the in-flight load: no rdvalid after deassertion.

## Configuration
- MMIO_ERR_CAPTURE_EN defined: error registers as specified.
- Not defined:
  - err_* outputs are tied to 0 and err_clr is ignored.
  - Illegal accesses are still suppressed, and errored loads still return 0 with rdvalid.

## Structure
- Package mmio_pkg holds:
  - memop encodings (MEMOP_B/H/W/BU/HU);
  - err_code constants;
  - the read-pipeline stage struct;
  - MAX_REGIONS=16.
- Sub-module mmio_lane_align: pure combinational lane logic (byte-enable/replicate on write, extract/extend on read).
- Decode, the pipeline and error capture stay in the top.

## Test plan
- Default params, sw 0x00100004 ← 0xDEADBEEF → slv_we=8'b0000_0010, slv_be=1111, slv_addr=0x4, no error.
- sb 0x00100003 ← 0x000000A5 → slv_be=1000, slv_wrdata=0xA5A5A5A5.
- Slave 1 word 0x80FF7F01:
  - lb at offset 3 → cpu_rddata=0xFFFFFF80, rdvalid at T+2;
  - lhu at offset 2 → 0x000080FF.
- lw 0x00900000 (unmapped) → no slv_re, rdvalid with 0.
  - err_valid=1, code 01, err_addr=0x00900000.
  - A second bad access sets err_overflow.
  - err_clr clears both.
- sw to region 0 (RO) → slv_we=0, code 11, err_is_write=1. lh 0x00100001 → code 10.
- RD_LATENCY=3, back-to-back lw to regions 1, 5, 1 → three consecutive rdvalid pulses T+4..T+6 with matching data. Pulling rst_n at T+2 yields no rdvalid.
